uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_rx_sync.sv | 15 +
 rtl/uart_rx.sv | 82 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver FSM states, data width and default bit period.
package uart_pkg;
  localparam int DATA_W = 8;
  localparam int CLKS_PER_BIT_DEF = 87;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
endpackage

// File: rtl/uart_rx_sync.sv
// rx_sync: multi-flop synchronizer for the async rx line, resets to idle-high.
module rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] r;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r <= '1;
    else r <= {r[SYNC_STAGES-2:0], d};
  assign q = r[SYNC_STAGES-1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with mid-bit sampling, one-byte holding register, framing and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_error,
  output logic              overrun
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  logic rx_s, done, ferr;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_n;
  logic [DATA_W-1:0] shift, shift_n;
  rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst_n(rst_n), .d(rx), .q(rx_s));
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    shift_n = shift;
    done    = 1'b0;
    ferr    = 1'b0;
    case (state)
      IDLE: if (!rx_s) begin
        state_n = START;
        cnt_n   = '0;
      end
      START: if (cnt == HALF) begin
        state_n = rx_s ? IDLE : DATA;
        cnt_n   = '0;
        bit_n   = '0;
      end else cnt_n = cnt + CW'(1);
      DATA: if (cnt == LAST) begin
        cnt_n   = '0;
        shift_n = {rx_s, shift[DATA_W-1:1]};
        bit_n   = bit_idx + 3'd1;
        state_n = (bit_idx == 3'd7) ? STOP : DATA;
      end else cnt_n = cnt + CW'(1);
      STOP: if (cnt == LAST) begin
        cnt_n   = '0;
        done    = rx_s;
        ferr    = !rx_s;
        state_n = rx_s ? IDLE : WAIT_IDLE;
      end else cnt_n = cnt + CW'(1);
      WAIT_IDLE: state_n = rx_s ? IDLE : WAIT_IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_n;
      shift       <= shift_n;
      frame_error <= ferr;
      overrun     <= done && rx_valid && !rx_ready;
      // a transfer in the completion cycle frees the holding register for the new byte
      if (done && (!rx_valid || rx_ready)) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
      end else if (rx_ready) rx_valid <= 1'b0;
    end
endmodule
